// File: rtl/g_aetcam_match_encoder_if.sv
// Search/result bus for the TCAM match encoder: search request, entry-valid write port and result channel.
interface g_aetcam_match_encoder_if #(
    parameter int ENTRIES = 32,
    parameter int WIDTH   = 16
);
    localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW = $clog2(ENTRIES + 1);

    logic [ENTRIES*WIDTH-1:0] en_w;
    logic                     s_valid;
    logic                     s_ready;
    logic                     v_wen;
    logic [AW-1:0]            v_addr;
    logic                     v_set;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_hit;
    logic [AW-1:0]            m_addr;
    logic [CW-1:0]            m_count;

    modport master (
        output en_w, s_valid, v_wen, v_addr, v_set, m_ready,
        input  s_ready, m_valid, m_hit, m_addr, m_count
    );

    modport slave (
        input  en_w, s_valid, v_wen, v_addr, v_set, m_ready,
        output s_ready, m_valid, m_hit, m_addr, m_count
    );
endinterface

// File: rtl/g_aetcam_match_encoder.sv
// Two-stage TCAM match-line priority encoder with per-entry valid bits.
// Optional match popcount on m_count enabled by macro G_AETCAM_MULTI_HIT_COUNT_EN.
module g_aetcam_match_encoder #(
    parameter int ENTRIES = 32,
    parameter int WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    g_aetcam_match_encoder_if.slave   bus
);
    localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW = $clog2(ENTRIES + 1);

    // Lowest set match line wins; no match yields index 0.
    function automatic logic [AW-1:0] prio_enc(input logic [ENTRIES-1:0] ml);
        logic [AW-1:0] a;
        logic          f;
        a = {AW{1'b0}};
        f = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ml[i] && !f) begin
                a = AW'(i);
                f = 1'b1;
            end else begin
                a = a;
            end
        end
        return a;
    endfunction

`ifdef G_AETCAM_MULTI_HIT_COUNT_EN
    function automatic logic [CW-1:0] popcount(input logic [ENTRIES-1:0] ml);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            c = c + CW'(ml[i]);
        end
        return c;
    endfunction
`endif

    logic [ENTRIES-1:0] valid_r;
    logic [ENTRIES-1:0] match_s;
    logic               s_ready_s;
    logic               s2_adv_s;
    logic               s1_valid_r;
    logic [ENTRIES-1:0] s1_match_r;
    logic               s2_valid_r;
    logic               s2_hit_r;
    logic [AW-1:0]      s2_addr_r;

    // Match line: every cell of the entry matches and the entry is valid.
    always_comb begin
        match_s = {ENTRIES{1'b0}};
        for (int e = 0; e < ENTRIES; e++) begin
            match_s[e] = (&bus.en_w[e*WIDTH +: WIDTH]) & valid_r[e];
        end
    end

    // Stage advance: S2 drains or is empty; S1 may load whenever S2 can take its content.
    always_comb begin
        s2_adv_s  = !s2_valid_r || bus.m_ready;
        s_ready_s = !s1_valid_r || s2_adv_s;
    end

    // Entry-valid flops; a search in the same cycle sees the pre-write value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (bus.v_wen) begin
            valid_r[bus.v_addr] <= bus.v_set;
        end else begin
            valid_r <= valid_r;
        end
    end

    // S1: capture match lines on an accepted search.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_match_r <= {ENTRIES{1'b0}};
        end else if (s_ready_s) begin
            s1_valid_r <= bus.s_valid;
            if (bus.s_valid) begin
                s1_match_r <= match_s;
            end else begin
                s1_match_r <= s1_match_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_match_r <= s1_match_r;
        end
    end

    // S2: encode hit and lowest index; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_hit_r   <= 1'b0;
            s2_addr_r  <= {AW{1'b0}};
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_hit_r  <= |s1_match_r;
                s2_addr_r <= prio_enc(s1_match_r);
            end else begin
                s2_hit_r  <= s2_hit_r;
                s2_addr_r <= s2_addr_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
            s2_hit_r   <= s2_hit_r;
            s2_addr_r  <= s2_addr_r;
        end
    end

`ifdef G_AETCAM_MULTI_HIT_COUNT_EN
    logic [CW-1:0] s2_count_r;

    // S2 match count, loaded alongside the encoded index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_count_r <= {CW{1'b0}};
        end else if (s2_adv_s && s1_valid_r) begin
            s2_count_r <= popcount(s1_match_r);
        end else begin
            s2_count_r <= s2_count_r;
        end
    end

    assign bus.m_count = s2_count_r;
`else
    assign bus.m_count = {CW{1'b0}};
`endif

    assign bus.s_ready = s_ready_s;
    assign bus.m_valid = s2_valid_r;
    assign bus.m_hit   = s2_hit_r;
    assign bus.m_addr  = s2_addr_r;
endmodule

// File: tb/tb_g_aetcam_match_encoder.sv
// Directed bench for g_aetcam_match_encoder: single/multi hit, masking, backpressure, reset, full match.
module tb_g_aetcam_match_encoder;
    localparam int ENTRIES = 32;
    localparam int WIDTH   = 16;
    localparam int N       = ENTRIES * WIDTH;
    localparam int AW      = 5;
    localparam int CW      = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    g_aetcam_match_encoder_if #(.ENTRIES(ENTRIES), .WIDTH(WIDTH)) bus ();

    g_aetcam_match_encoder #(.ENTRIES(ENTRIES), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef G_AETCAM_MULTI_HIT_COUNT_EN
        return CW'(n);
`else
        return CW'(n) & {CW{1'b0}};
`endif
    endfunction

    // en_w pattern with every cell of the selected entries matching.
    function automatic logic [N-1:0] full_mask(input logic [ENTRIES-1:0] ents);
        logic [N-1:0] v;
        v = {N{1'b0}};
        for (int e = 0; e < ENTRIES; e++) begin
            if (ents[e]) v[e*WIDTH +: WIDTH] = {WIDTH{1'b1}};
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en_w    = {N{1'b0}};
        bus.s_valid = 1'b0;
        bus.v_wen   = 1'b0;
        bus.v_addr  = {AW{1'b0}};
        bus.v_set   = 1'b0;
        bus.m_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic write_valid(input logic [AW-1:0] a, input logic v);
        bus.v_wen  = 1'b1;
        bus.v_addr = a;
        bus.v_set  = v;
        step();
        bus.v_wen  = 1'b0;
    endtask

    // One search with m_ready=1 and an optional valid write in the accept cycle.
    task automatic run_search(input logic [N-1:0] en, input logic vw, input logic [AW-1:0] va,
                              input logic vs, output logic ov, output logic oh,
                              output logic [AW-1:0] oa, output logic [CW-1:0] oc, output int lat);
        bus.en_w    = en;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        bus.v_wen   = vw;
        bus.v_addr  = va;
        bus.v_set   = vs;
        step();
        bus.s_valid = 1'b0;
        bus.v_wen   = 1'b0;
        lat = 1;
        while (bus.m_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        ov = bus.m_valid;
        oh = bus.m_hit;
        oa = bus.m_addr;
        oc = bus.m_count;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
        checks++; if (bus.m_hit !== 1'b0) begin failures++; $display("FAIL reset_m_hit got=%b exp=0", bus.m_hit); end
        checks++; if (bus.m_addr !== 5'd0) begin failures++; $display("FAIL reset_m_addr got=%0d exp=0", bus.m_addr); end
        checks++; if (bus.m_count !== 6'd0) begin failures++; $display("FAIL reset_m_count got=%0d exp=0", bus.m_count); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", bus.s_ready); end
    endtask

    task automatic test_single_hit();
        logic ov, oh; logic [AW-1:0] oa; logic [CW-1:0] oc; int lat;
        apply_reset();
        write_valid(5'd5, 1'b1);
        run_search(full_mask(32'h0000_0020), 1'b0, 5'd0, 1'b0, ov, oh, oa, oc, lat);
        checks++; if (ov !== 1'b1 || lat !== 2) begin failures++; $display("FAIL single_latency got=%0d valid=%b exp=2", lat, ov); end
        checks++; if (oh !== 1'b1) begin failures++; $display("FAIL single_hit got=%b exp=1", oh); end
        checks++; if (oa !== 5'd5) begin failures++; $display("FAIL single_addr got=%0d exp=5", oa); end
        checks++; if (oc !== exp_cnt(1)) begin failures++; $display("FAIL single_count got=%0d exp=%0d", oc, exp_cnt(1)); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", bus.m_valid); end
    endtask

    task automatic test_multi_hit();
        logic ov, oh; logic [AW-1:0] oa; logic [CW-1:0] oc; int lat;
        apply_reset();
        write_valid(5'd3, 1'b1);
        write_valid(5'd9, 1'b1);
        write_valid(5'd20, 1'b1);
        run_search({N{1'b1}}, 1'b0, 5'd0, 1'b0, ov, oh, oa, oc, lat);
        checks++; if (ov !== 1'b1 || oh !== 1'b1) begin failures++; $display("FAIL multi_hit got=%b/%b exp=1/1", ov, oh); end
        checks++; if (oa !== 5'd3) begin failures++; $display("FAIL multi_addr got=%0d exp=3", oa); end
        checks++; if (oc !== exp_cnt(3)) begin failures++; $display("FAIL multi_count got=%0d exp=%0d", oc, exp_cnt(3)); end
    endtask

    task automatic test_invalid_mask();
        logic ov, oh; logic [AW-1:0] oa; logic [CW-1:0] oc; int lat;
        logic [N-1:0] part;
        apply_reset();
        run_search(full_mask(32'h0000_0080), 1'b1, 5'd7, 1'b1, ov, oh, oa, oc, lat);
        checks++; if (ov !== 1'b1 || oh !== 1'b0) begin failures++; $display("FAIL mask_miss got=%b/%b exp=1/0", ov, oh); end
        checks++; if (oa !== 5'd0 || oc !== 6'd0) begin failures++; $display("FAIL mask_miss_addr got=%0d/%0d exp=0/0", oa, oc); end
        run_search(full_mask(32'h0000_0080), 1'b0, 5'd0, 1'b0, ov, oh, oa, oc, lat);
        checks++; if (oh !== 1'b1 || oa !== 5'd7) begin failures++; $display("FAIL mask_next_hit got=%b/%0d exp=1/7", oh, oa); end
        checks++; if (oc !== exp_cnt(1)) begin failures++; $display("FAIL mask_next_count got=%0d exp=%0d", oc, exp_cnt(1)); end
        part = full_mask(32'h0000_0080);
        part[7*WIDTH + 11] = 1'b0;
        run_search(part, 1'b0, 5'd0, 1'b0, ov, oh, oa, oc, lat);
        checks++; if (oh !== 1'b0 || oa !== 5'd0) begin failures++; $display("FAIL partial_cell got=%b/%0d exp=0/0", oh, oa); end
    endtask

    task automatic test_capture_isolation();
        logic ov, oh; logic [AW-1:0] oa; logic [CW-1:0] oc; int lat;
        apply_reset();
        write_valid(5'd7, 1'b1);
        bus.en_w    = full_mask(32'h0000_0080);
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        step();
        bus.s_valid = 1'b0;
        bus.v_wen   = 1'b1;
        bus.v_addr  = 5'd7;
        bus.v_set   = 1'b0;
        step();
        bus.v_wen   = 1'b0;
        checks++; if (bus.m_valid !== 1'b1 || bus.m_hit !== 1'b1 || bus.m_addr !== 5'd7) begin
            failures++; $display("FAIL isolation got=%b/%b/%0d exp=1/1/7", bus.m_valid, bus.m_hit, bus.m_addr); end
        step();
        run_search(full_mask(32'h0000_0080), 1'b0, 5'd0, 1'b0, ov, oh, oa, oc, lat);
        checks++; if (oh !== 1'b0) begin failures++; $display("FAIL isolation_after got=%b exp=0", oh); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]  bp_en [4];
        logic [AW-1:0] bp_addr [4];
        int            bp_n [4];
        int            idx, ridx;
        apply_reset();
        for (int k = 1; k <= 4; k++) write_valid(AW'(k), 1'b1);
        bp_en[0] = full_mask(32'h0000_0003); bp_addr[0] = 5'd1; bp_n[0] = 1;
        bp_en[1] = full_mask(32'h0000_000C); bp_addr[1] = 5'd2; bp_n[1] = 2;
        bp_en[2] = full_mask(32'h0000_0018); bp_addr[2] = 5'd3; bp_n[2] = 2;
        bp_en[3] = full_mask(32'h0000_0010); bp_addr[3] = 5'd4; bp_n[3] = 1;
        idx = 0;
        ridx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            bus.m_ready = (cyc >= 3);
            if (idx < 4) begin
                bus.s_valid = 1'b1;
                bus.en_w    = bp_en[idx];
            end else begin
                bus.s_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                checks++; if (bus.s_ready !== 1'b0 || idx !== 2) begin
                    failures++; $display("FAIL bp_stall got=s_ready %b accepted %0d exp=0/2", bus.s_ready, idx); end
                checks++; if (bus.m_valid !== 1'b1 || bus.m_addr !== 5'd1) begin
                    failures++; $display("FAIL bp_hold got=%b/%0d exp=1/1", bus.m_valid, bus.m_addr); end
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1 && ridx < 4) begin
                checks++; if (bus.m_hit !== 1'b1 || bus.m_addr !== bp_addr[ridx] || bus.m_count !== exp_cnt(bp_n[ridx])) begin
                    failures++; $display("FAIL bp_result%0d got=%b/%0d/%0d exp=1/%0d/%0d", ridx, bus.m_hit,
                                         bus.m_addr, bus.m_count, bp_addr[ridx], exp_cnt(bp_n[ridx])); end
                ridx++;
            end
            if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) idx++;
            step();
        end
        checks++; if (ridx !== 4 || idx !== 4) begin failures++; $display("FAIL bp_total got=%0d/%0d exp=4/4", idx, ridx); end
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic ov, oh; logic [AW-1:0] oa; logic [CW-1:0] oc; int lat;
        apply_reset();
        write_valid(5'd5, 1'b1);
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.en_w    = full_mask(32'h0000_0020);
        step();
        step();
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL midrst_s_ready_during got=%b exp=1", bus.s_ready); end
        step();
        rst_n = 1'b1;
        checks++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_after got=m_valid %b s_ready %b exp=0/1", bus.m_valid, bus.s_ready); end
        step();
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL midrst_discard got=%b exp=0", bus.m_valid); end
        run_search({N{1'b1}}, 1'b0, 5'd0, 1'b0, ov, oh, oa, oc, lat);
        checks++; if (ov !== 1'b1 || oh !== 1'b0 || oa !== 5'd0 || oc !== 6'd0) begin
            failures++; $display("FAIL midrst_search got=%b/%b/%0d/%0d exp=1/0/0/0", ov, oh, oa, oc); end
    endtask

    task automatic test_full_match();
        logic ov, oh; logic [AW-1:0] oa; logic [CW-1:0] oc; int lat;
        apply_reset();
        for (int k = 0; k < ENTRIES; k++) write_valid(AW'(k), 1'b1);
        run_search({N{1'b1}}, 1'b0, 5'd0, 1'b0, ov, oh, oa, oc, lat);
        checks++; if (ov !== 1'b1 || oh !== 1'b1 || oa !== 5'd0) begin
            failures++; $display("FAIL full_addr got=%b/%b/%0d exp=1/1/0", ov, oh, oa); end
        checks++; if (oc !== exp_cnt(32)) begin failures++; $display("FAIL full_count got=%0d exp=%0d", oc, exp_cnt(32)); end
        run_search(full_mask(32'h8000_0000), 1'b0, 5'd0, 1'b0, ov, oh, oa, oc, lat);
        checks++; if (oh !== 1'b1 || oa !== 5'd31 || oc !== exp_cnt(1)) begin
            failures++; $display("FAIL top_entry got=%b/%0d/%0d exp=1/31/%0d", oh, oa, oc, exp_cnt(1)); end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_hit();
        test_multi_hit();
        test_invalid_mask();
        test_capture_isolation();
        test_back_to_back();
        test_reset_midflight();
        test_full_match();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
